// File: rtl/branch_resolve_queue_if.sv
// Fetch/resolve/BHT-update bundle for the branch resolve queue.
// master = pipeline side, slave = queue side.
interface branch_resolve_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            fetch_valid;
  logic [PC_W-1:0] fetch_pc;
  logic            fetch_pred;
  logic            fetch_ready;
  logic            resolve_valid;
  logic            resolve_taken;
  logic            flush;
  logic            bht_write;
  logic [PC_W-1:0] bht_write_pc;
  logic            bht_taken;
  logic            mispredict;
  logic [CW-1:0]   count;

  modport master (
    output fetch_valid, fetch_pc, fetch_pred,
    output resolve_valid, resolve_taken, flush,
    input  fetch_ready, bht_write, bht_write_pc,
    input  bht_taken, mispredict, count
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_pred,
    input  resolve_valid, resolve_taken, flush,
    output fetch_ready, bht_write, bht_write_pc,
    output bht_taken, mispredict, count
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches driving BHT updates and mispredicts.
// Define BRQ_STATS_EN for saturating branch/mispredict counters.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
) (
  input  logic clk,
  input  logic reset_n,
  branch_resolve_queue_if.slave bus
`ifdef BRQ_STATS_EN
  ,
  output logic [15:0] stat_branches,
  output logic [15:0] stat_mispred
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [PC_W-1:0]  pc_q [DEPTH];
  logic [DEPTH-1:0] pred_q;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW:0]      rd_q, rd_d;
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      occ;
  logic [AW-1:0]    head, wslot;
  logic             full, empty;
  logic             pop, mis, push, kill;

  logic             bw_q;
  logic [PC_W-1:0]  bpc_q;
  logic             btk_q;
  logic             mp_q;

  assign head  = rd_q[AW-1:0];
  assign wslot = wr_q[AW-1:0];
  assign occ   = wr_q - rd_q;
  assign full  = (occ == FULL_CNT);
  assign empty = (occ == '0);

  // Handshake decode and next pointer/valid state.
  always_comb begin
    pop   = bus.resolve_valid && !empty && vld_q[head];
    mis   = pop && (pred_q[head] != bus.resolve_taken);
    kill  = mis || bus.flush;
    push  = bus.fetch_valid && !full && !kill;
    rd_d  = pop ? rd_q + PTR_ONE : rd_q;
    wr_d  = kill ? rd_d : (push ? wr_q + PTR_ONE : wr_q);
    vld_d = vld_q;
    if (pop) vld_d[head] = 1'b0;
    if (kill) vld_d = '0;
    else if (push) vld_d[wslot] = 1'b1;
  end

  // Pointers, entry storage and registered BHT-update outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      vld_q  <= '0;
      pred_q <= '0;
      for (int i = 0; i < DEPTH; i++) pc_q[i] <= '0;
      bw_q   <= 1'b0;
      bpc_q  <= '0;
      btk_q  <= 1'b0;
      mp_q   <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      vld_q <= vld_d;
      if (push) begin
        pc_q[wslot]   <= bus.fetch_pc;
        pred_q[wslot] <= bus.fetch_pred;
      end
      bw_q <= pop;
      mp_q <= mis;
      if (pop) begin
        bpc_q <= pc_q[head];
        btk_q <= bus.resolve_taken;
      end
    end
  end

  assign bus.fetch_ready  = !full;
  assign bus.count        = occ;
  assign bus.bht_write    = bw_q;
  assign bus.bht_write_pc = bpc_q;
  assign bus.bht_taken    = btk_q;
  assign bus.mispredict   = mp_q;

`ifdef BRQ_STATS_EN
  logic [15:0] sb_q, sm_q;

  // Saturating resolve/mispredict counters; only reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_q <= '0;
      sm_q <= '0;
    end else begin
      if (pop && sb_q != 16'hFFFF) sb_q <= sb_q + 16'd1;
      if (mis && sm_q != 16'hFFFF) sm_q <= sm_q + 16'd1;
    end
  end

  assign stat_branches = sb_q;
  assign stat_mispred  = sm_q;
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue.
// Expected BHT updates queued at resolve, checked when bht_write fires.
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            tk;
    logic            mis;
  } exp_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   st_br = 0;
  int   st_mp = 0;
  exp_t sb[$];
  ent_t mq[$];

  branch_resolve_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bif ();

`ifdef BRQ_STATS_EN
  logic [15:0] stat_branches, stat_mispred;
`endif

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bif.slave)
`ifdef BRQ_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every bht_write must match the oldest expected update.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bif.bht_write) begin
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_bht_write pc=%h", bif.bht_write_pc);
        end else begin
          e = sb.pop_front();
          if (bif.bht_write_pc !== e.pc || bif.bht_taken !== e.tk ||
              bif.mispredict !== e.mis) begin
            n_bad++;
            $display("FAIL bht_update got pc=%h tk=%b mis=%b want pc=%h tk=%b mis=%b",
                     bif.bht_write_pc, bif.bht_taken, bif.mispredict,
                     e.pc, e.tk, e.mis);
          end
        end
      end else if (bif.mispredict) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_mispredict got 1 want 0");
      end
    end
  end

  // One clock of stimulus; the FIFO model predicts the resulting update.
  task automatic cyc(input logic fv, input logic [PC_W-1:0] pc,
                     input logic pr, input logic rv,
                     input logic tk, input logic fl);
    bit full, mis;
    ent_t h;
    full = (mq.size() == DEPTH);
    mis = 1'b0;
    bif.fetch_valid   = fv;
    bif.fetch_pc      = pc;
    bif.fetch_pred    = pr;
    bif.resolve_valid = rv;
    bif.resolve_taken = tk;
    bif.flush         = fl;
    if (rv && mq.size() > 0) begin
      h = mq.pop_front();
      mis = (h.pred != tk);
      sb.push_back('{pc: h.pc, tk: tk, mis: mis});
      st_br++;
      if (mis) st_mp++;
    end
    if (fl || mis) mq.delete();
    else if (fv && !full) mq.push_back('{pc: pc, pred: pr});
    @(posedge clk);
    #1;
    bif.fetch_valid   = 1'b0;
    bif.resolve_valid = 1'b0;
    bif.flush         = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    bif.fetch_valid = 0; bif.fetch_pc = '0; bif.fetch_pred = 0;
    bif.resolve_valid = 0; bif.resolve_taken = 0; bif.flush = 0;
    reset_n = 1'b0;
    sb.delete(); mq.delete();
    st_br = 0; st_mp = 0;
    #12;
    n_cmp += 6;
    if (bif.count !== '0) begin n_bad++;
      $display("FAIL rst_count got %0d want 0", bif.count); end
    if (bif.fetch_ready !== 1'b1) begin n_bad++;
      $display("FAIL rst_ready got %b want 1", bif.fetch_ready); end
    if (bif.bht_write !== 1'b0) begin n_bad++;
      $display("FAIL rst_bw got %b want 0", bif.bht_write); end
    if (bif.bht_write_pc !== '0) begin n_bad++;
      $display("FAIL rst_bpc got %h want 0", bif.bht_write_pc); end
    if (bif.bht_taken !== 1'b0) begin n_bad++;
      $display("FAIL rst_btk got %b want 0", bif.bht_taken); end
    if (bif.mispredict !== 1'b0) begin n_bad++;
      $display("FAIL rst_mis got %b want 0", bif.mispredict); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    cyc(1, 16'h3000, 1, 0, 0, 0);
    cyc(0, '0, 0, 1, 1, 0);
    n_cmp += 2;
    if (bif.bht_write !== 1'b1) begin n_bad++;
      $display("FAIL basic_bw got %b want 1", bif.bht_write); end
    if (bif.count !== CW'(0)) begin n_bad++;
      $display("FAIL basic_count got %0d want 0", bif.count); end
    idle();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++)
      cyc(1, PC_W'(16'h1000 + 2 * i), i[0], 0, 0, 0);
    n_cmp += 2;
    if (bif.fetch_ready !== 1'b0) begin n_bad++;
      $display("FAIL full_ready got %b want 0", bif.fetch_ready); end
    if (bif.count !== CW'(DEPTH)) begin n_bad++;
      $display("FAIL full_count got %0d want %0d", bif.count, DEPTH); end
    cyc(1, 16'h4000, 0, 0, 0, 0);
    n_cmp++;
    if (bif.count !== CW'(DEPTH)) begin n_bad++;
      $display("FAIL full_drop got %0d want %0d", bif.count, DEPTH); end
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, '0, 0, 1, i[0], 0);
    idle();
    n_cmp += 2;
    if (bif.count !== CW'(0)) begin n_bad++;
      $display("FAIL full_drain got %0d want 0", bif.count); end
    if (sb.size() != 0) begin n_bad++;
      $display("FAIL full_sb got %0d want 0", sb.size()); end
  endtask

  task automatic test_mispredict();
    cyc(1, 16'h3000, 0, 0, 0, 0);
    cyc(1, 16'h3002, 1, 0, 0, 0);
    cyc(1, 16'h3004, 1, 0, 0, 0);
    cyc(1, 16'h3006, 1, 1, 1, 0);
    n_cmp += 2;
    if (bif.mispredict !== 1'b1) begin n_bad++;
      $display("FAIL mp_pulse got %b want 1", bif.mispredict); end
    if (bif.count !== CW'(0)) begin n_bad++;
      $display("FAIL mp_count got %0d want 0", bif.count); end
    cyc(0, '0, 0, 1, 1, 0);
    n_cmp++;
    if (bif.bht_write !== 1'b0) begin n_bad++;
      $display("FAIL mp_after got %b want 0", bif.bht_write); end
    idle();
  endtask

  task automatic test_flush();
    cyc(1, 16'h5000, 1, 0, 0, 0);
    cyc(1, 16'h5002, 0, 0, 0, 0);
    cyc(1, 16'h5004, 0, 1, 1, 1);
    n_cmp += 2;
    if (bif.bht_write !== 1'b1) begin n_bad++;
      $display("FAIL fl_bw got %b want 1", bif.bht_write); end
    if (bif.count !== CW'(0)) begin n_bad++;
      $display("FAIL fl_count got %0d want 0", bif.count); end
    cyc(0, '0, 0, 1, 0, 0);
    n_cmp++;
    if (bif.bht_write !== 1'b0) begin n_bad++;
      $display("FAIL fl_after got %b want 0", bif.bht_write); end
    idle();
  endtask

  task automatic test_back_to_back();
    cyc(1, 16'h6000, 1, 0, 0, 0);
    for (int i = 1; i <= 3 * DEPTH; i++) begin
      cyc(1, PC_W'(16'h6000 + 4 * i), 1, 1, 1, 0);
      n_cmp++;
      if (bif.count !== CW'(1)) begin n_bad++;
        $display("FAIL b2b_count[%0d] got %0d want 1", i, bif.count); end
    end
    cyc(0, '0, 0, 1, 1, 0);
    idle();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++;
      $display("FAIL b2b_sb got %0d want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    cyc(1, 16'h7000, 1, 0, 0, 0);
    cyc(1, 16'h7002, 1, 0, 0, 0);
    cyc(0, '0, 0, 1, 0, 0);
    n_cmp++;
    if (bif.bht_write !== 1'b1) begin n_bad++;
      $display("FAIL mid_pend got %b want 1", bif.bht_write); end
`ifdef BRQ_STATS_EN
    n_cmp += 2;
    if (stat_branches !== 16'(st_br)) begin n_bad++;
      $display("FAIL stat_br got %0d want %0d", stat_branches, st_br); end
    if (stat_mispred !== 16'(st_mp)) begin n_bad++;
      $display("FAIL stat_mp got %0d want %0d", stat_mispred, st_mp); end
`endif
    #1;
    reset_n = 1'b0;
    sb.delete(); mq.delete();
    #1;
    n_cmp += 4;
    if (bif.bht_write !== 1'b0) begin n_bad++;
      $display("FAIL mid_bw got %b want 0", bif.bht_write); end
    if (bif.mispredict !== 1'b0) begin n_bad++;
      $display("FAIL mid_mis got %b want 0", bif.mispredict); end
    if (bif.bht_write_pc !== '0) begin n_bad++;
      $display("FAIL mid_bpc got %h want 0", bif.bht_write_pc); end
    if (bif.count !== CW'(0)) begin n_bad++;
      $display("FAIL mid_count got %0d want 0", bif.count); end
`ifdef BRQ_STATS_EN
    n_cmp++;
    if (stat_branches !== 16'd0 || stat_mispred !== 16'd0) begin n_bad++;
      $display("FAIL mid_stats got %0d/%0d want 0/0",
               stat_branches, stat_mispred); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    st_br = 0; st_mp = 0;
    cyc(0, '0, 0, 1, 1, 0);
    n_cmp++;
    if (bif.bht_write !== 1'b0) begin n_bad++;
      $display("FAIL mid_lost got %b want 0", bif.bht_write); end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_mispredict();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
